// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, LSB first, one byte per frame.
// Streams back-to-back frames while tx_en is held high. tx_data_in is
// re-sampled at the start of every frame.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// after data bit 7, which makes the frame 11 bits long.
// All outputs are registered. Reset is asynchronous and active-high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_en,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_out,
    output logic       start,
    output logic       busy,
    output logic       done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    data_reg;
    logic          baud_tc;

    // Terminal count of the per-bit baud counter
    assign baud_tc = (baud_cnt == BAUD_LAST);

    // Frame sequencer: the state, counters, latched byte and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            data_reg    <= '0;
            tx_data_out <= 1'b1;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    tx_data_out <= 1'b1;
                    busy        <= 1'b0;
                    if (tx_en) begin
                        data_reg    <= tx_data_in;
                        bit_idx     <= '0;
                        baud_cnt    <= '0;
                        state       <= START;
                        tx_data_out <= 1'b0;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tc) begin
                        baud_cnt    <= '0;
                        state       <= DATA;
                        tx_data_out <= data_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state       <= PARITY;
                            tx_data_out <= ^data_reg;
`else
                            state       <= STOP;
                            tx_data_out <= 1'b1;
`endif
                        end else begin
                            // The bit to drive next is looked up ahead of the
                            // index update, so the line is already correct on
                            // the first cycle of that bit.
                            bit_idx     <= bit_idx + 3'd1;
                            tx_data_out <= data_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tc) begin
                        baud_cnt    <= '0;
                        state       <= STOP;
                        tx_data_out <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    tx_data_out <= 1'b1;
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DONE: begin
                    tx_data_out <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    baud_cnt    <= '0;
                    tx_data_out <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with CLKS_PER_BIT=4 and a 40 ns clock.
// The expected waveform is computed from the frame format: a start bit of 0,
// then the 8 data bits LSB first, then an optional even-parity bit, then a
// stop bit of 1. Each bit lasts CPB cycles. After the frame come one DONE
// cycle and one IDLE cycle.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_en;
    logic [7:0] tx_data_in;
    logic       tx_data_out;
    logic       start;
    logic       busy;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;

    always #20 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .tx_data_in (tx_data_in),
        .tx_data_out(tx_data_out),
        .start      (start),
        .busy       (busy),
        .done       (done)
    );

    // Line value at bit position pos of the frame that carries byte b
    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
        if (NBITS == 11 && pos == 9) return ^b;
        return 1'b1;
    endfunction

    // Compare {line, start, busy, done} with the expected value
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {tx_data_out, start, busy, done};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (line,start,busy,done)", tag, obs, exp);
        end
    endtask

    // Check that the DUT sits idle for n cycles
    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s idle %0d", tag, i), 4'b1000);
        end
    endtask

    // Follow one frame cycle by cycle. Call this at a negedge with tx_en=1 and
    // tx_data_in=b already set. The input data is scrambled during bit 3,
    // tx_en is dropped at drop_cycle, and next_b is applied in the DONE cycle.
    // The task returns at the negedge of the IDLE cycle that follows the frame.
    task automatic run_frame(input logic [7:0] b, input int drop_cycle, input logic [7:0] next_b);
        logic [3:0] exp;
        for (int c = 0; c <= FL + 1; c++) begin
            @(negedge clk);
            if (c < FL)       exp = {frame_bit(b, c / CPB), (c == 0), 1'b1, 1'b0};
            else if (c == FL) exp = 4'b1001;
            else              exp = 4'b1000;
            check($sformatf("frame %02h cyc %0d", b, c), exp);
            if (c == 4 * CPB + 1) tx_data_in = ~b;
            if (c == drop_cycle)  tx_en = 1'b0;
            if (c == FL)          tx_data_in = next_b;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] nb;

        // Reset state
        reset      = 1'b1;
        tx_en      = 1'b0;
        tx_data_in = 8'h00;
        repeat (2) @(negedge clk);
        check("reset state", 4'b1000);
        reset = 1'b0;
        idle_check(3, "post reset");

        // Single frame 0xAA; tx_en drops in the DONE cycle
        tx_data_in = 8'hAA;
        tx_en      = 1'b1;
        run_frame(8'hAA, FL, 8'h00);
        idle_check(6, "after single");

        // Streaming with tx_en held; each new byte is applied while done is high
        tx_data_in = 8'hAA;
        tx_en      = 1'b1;
        run_frame(8'hAA, -1, 8'hCC);
        run_frame(8'hCC, -1, 8'hF0);
        run_frame(8'hF0, -1, 8'h0F);
        run_frame(8'h0F, FL, 8'h55);
        idle_check(4, "after stream");

        // Random back-to-back frames
        b          = 8'($urandom);
        tx_data_in = b;
        tx_en      = 1'b1;
        for (int f = 0; f < 6; f++) begin
            nb = 8'($urandom);
            run_frame(b, (f == 5) ? FL : -1, nb);
            b = nb;
        end
        idle_check(4, "after random");

        // Parity-sensitive byte (0x07 has odd weight, so its even parity bit is 1)
        tx_data_in = 8'h07;
        tx_en      = 1'b1;
        run_frame(8'h07, FL, 8'h00);
        idle_check(3, "after 07");

        // tx_en dropped during bit 3: the frame completes, then the DUT stays idle
        b          = 8'($urandom);
        tx_data_in = b;
        tx_en      = 1'b1;
        run_frame(b, 4 * CPB + 1, 8'($urandom));
        idle_check(3 * FL, "after drop");

        // Reset asserted mid-frame, between clock edges
        tx_data_in = 8'($urandom);
        tx_en      = 1'b1;
        repeat (10) @(negedge clk);
        check("busy before reset", {1'b0, 1'b0, 1'b1, 1'b0} | {tx_data_out, 3'b000});
        #5 reset = 1'b1;
        #1 check("async reset", 4'b1000);
        tx_en = 1'b0;
        @(negedge clk);
        check("held reset", 4'b1000);
        reset = 1'b0;
        idle_check(20, "after mid reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
